// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg
//   Shared definitions for the pipeline hazard / forwarding controller:
//   result-kind codes, tuse/tnew constants, forwarding select codes, the
//   per-stage producer record and the helpers that match and encode selects.
//   No ports (package).
package hazard_fwd_ctrl_pkg;

  // Result source of a producing instruction
  localparam logic [2:0] KIND_ALU = 3'd0;
  localparam logic [2:0] KIND_DM  = 3'd1;
  localparam logic [2:0] KIND_PC  = 3'd2;
  localparam logic [2:0] KIND_HI  = 3'd3;
  localparam logic [2:0] KIND_LO  = 3'd4;

  // Cycles until an operand is consumed, counted from D
  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  // Result latency counted from E entry
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // Multiply/divide operation issued from D
  localparam logic [1:0] MDOP_NONE = 2'd0;
  localparam logic [1:0] MDOP_MULT = 2'd1;
  localparam logic [1:0] MDOP_DIV  = 2'd2;

  // Forwarding select codes shared by every forwarding mux
  localparam logic [3:0] SEL_NONE  = 4'd0;
  localparam logic [3:0] SEL_M_ALU = 4'd1;
  localparam logic [3:0] SEL_M_PC  = 4'd2;
  localparam logic [3:0] SEL_M_HI  = 4'd3;
  localparam logic [3:0] SEL_M_LO  = 4'd4;
  localparam logic [3:0] SEL_W_ALU = 4'd5;
  localparam logic [3:0] SEL_W_DM  = 4'd6;
  localparam logic [3:0] SEL_W_PC  = 4'd7;
  localparam logic [3:0] SEL_W_HI  = 4'd8;
  localparam logic [3:0] SEL_W_LO  = 4'd9;

  // Per-destination aliases: source stage then consuming stage
  localparam logic [3:0] MD_ALU = SEL_M_ALU;
  localparam logic [3:0] MD_PC  = SEL_M_PC;
  localparam logic [3:0] MD_HI  = SEL_M_HI;
  localparam logic [3:0] MD_LO  = SEL_M_LO;
  localparam logic [3:0] ME_ALU = SEL_M_ALU;
  localparam logic [3:0] ME_PC  = SEL_M_PC;
  localparam logic [3:0] ME_HI  = SEL_M_HI;
  localparam logic [3:0] ME_LO  = SEL_M_LO;
  localparam logic [3:0] WD_ALU = SEL_W_ALU;
  localparam logic [3:0] WD_DM  = SEL_W_DM;
  localparam logic [3:0] WD_PC  = SEL_W_PC;
  localparam logic [3:0] WD_HI  = SEL_W_HI;
  localparam logic [3:0] WD_LO  = SEL_W_LO;
  localparam logic [3:0] WE_ALU = SEL_W_ALU;
  localparam logic [3:0] WE_DM  = SEL_W_DM;
  localparam logic [3:0] WE_PC  = SEL_W_PC;
  localparam logic [3:0] WE_HI  = SEL_W_HI;
  localparam logic [3:0] WE_LO  = SEL_W_LO;
  localparam logic [3:0] WM_ALU = SEL_W_ALU;
  localparam logic [3:0] WM_DM  = SEL_W_DM;
  localparam logic [3:0] WM_PC  = SEL_W_PC;
  localparam logic [3:0] WM_HI  = SEL_W_HI;
  localparam logic [3:0] WM_LO  = SEL_W_LO;

  // Producer record carried alongside each pipeline stage
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [2:0] kind;
  } stage_rec_t;

  // Register 0 is hard-wired, so it never creates a dependency
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] dst);
    return (r != 5'd0) && (r == dst);
  endfunction

  // A load in M has no M-stage tap; it is only ever picked up from W
  function automatic logic [3:0] m_sel(input logic [2:0] kind);
    case (kind)
      KIND_ALU: return SEL_M_ALU;
      KIND_PC:  return SEL_M_PC;
      KIND_HI:  return SEL_M_HI;
      KIND_LO:  return SEL_M_LO;
      default:  return SEL_NONE;
    endcase
  endfunction

  function automatic logic [3:0] w_sel(input logic [2:0] kind);
    case (kind)
      KIND_ALU: return SEL_W_ALU;
      KIND_DM:  return SEL_W_DM;
      KIND_PC:  return SEL_W_PC;
      KIND_HI:  return SEL_W_HI;
      KIND_LO:  return SEL_W_LO;
      default:  return SEL_NONE;
    endcase
  endfunction

  // M only forwards once its result exists (tnew 0); otherwise W may
  // still supply an older value, and the stall logic covers the gap
  function automatic logic [3:0] fwd_sel(input logic [4:0] r,
                                         input stage_rec_t m,
                                         input stage_rec_t w);
    if (reg_match(r, m.dst) && (m.tnew == 2'd0)) return m_sel(m.kind);
    if (reg_match(r, w.dst))                     return w_sel(w.kind);
    return SEL_NONE;
  endfunction

  // Producer will not have its value ready by the time the operand is used
  function automatic logic raw_stall(input logic [4:0] r,
                                     input logic [1:0] tuse,
                                     input stage_rec_t p);
    return reg_match(r, p.dst) && (p.tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if
//   Bundle between the D-stage decoder (master) and the hazard controller
//   (slave).
//   Decoder -> controller: rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D,
//                          kind_D, md_op_D, md_use_D
//   Controller -> decoder/datapath: stall, MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM
interface hazard_fwd_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] tuse_rs_D;
  logic [1:0] tuse_rt_D;
  logic [4:0] dst_D;
  logic [1:0] tnew_D;
  logic [2:0] kind_D;
  logic [1:0] md_op_D;
  logic       md_use_D;
  logic       stall;
  logic [3:0] MCMP1D;
  logic [3:0] MCMP2D;
  logic [3:0] MALUAE;
  logic [3:0] MALUBE;
  logic [3:0] MWDM;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D, kind_D,
           md_op_D, md_use_D,
    input  stall, MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, dst_D, tnew_D, kind_D,
           md_op_D, md_use_D,
    output stall, MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM
  );
endinterface

// File: rtl/hazard_stage_rec.sv
// hazard_stage_rec
//   One pipeline stage's producer record. Captures the previous stage's
//   record each clock, optionally counting tnew down by one (floor 0), or
//   loads an all-zero bubble.
//   Ports: clk, reset (sync, active-low), rec_i (upstream record),
//          bubble_i (load zero instead), rec_o (registered record).
module hazard_stage_rec
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  stage_rec_t rec_i,
  input  logic       bubble_i,
  output stage_rec_t rec_o
);

  stage_rec_t rec_d;
  stage_rec_t rec_q;

  // Next record: age the result latency by one stage, or squash to a bubble
  always_comb begin
    rec_d = rec_i;
    if (DEC_TNEW && (rec_i.tnew != 2'd0)) begin
      rec_d.tnew = rec_i.tnew - 2'd1;
    end
    if (bubble_i) begin
      rec_d = '0;
    end
  end

  // Record register, cleared by the synchronous low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Pipeline hazard controller. Tracks E/M/W producer records, drives the
//   D-stage stall and the forwarding selects for the D comparator, the E ALU
//   inputs and the M store data.
//   Ports: clk, reset (sync, active-low), hif (hazard_fwd_ctrl_if.slave).
//   Parameters: MULT_CYC, DIV_CYC - mult/div unit busy cycles.
//   Build option: HAZ_MD_STALL_EN adds the mult/div busy counter and its
//   stall term; without it the multiply unit handles its own stalls.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic             clk,
  input  logic             reset,
  hazard_fwd_ctrl_if.slave hif
);

  stage_rec_t d_rec;
  stage_rec_t e_rec;
  stage_rec_t m_rec;
  stage_rec_t w_rec;
  logic       raw_stall_c;
  logic       md_stall_c;
  logic       stall_c;

  // Record presented by the D-stage decoder
  always_comb begin
    d_rec      = '0;
    d_rec.rs   = hif.rs_D;
    d_rec.rt   = hif.rt_D;
    d_rec.dst  = hif.dst_D;
    d_rec.tnew = hif.tnew_D;
    d_rec.kind = hif.kind_D;
  end

  hazard_stage_rec #(.DEC_TNEW(1'b0)) u_rec_e (
    .clk      (clk),
    .reset    (reset),
    .rec_i    (d_rec),
    .bubble_i (stall_c),
    .rec_o    (e_rec)
  );

  hazard_stage_rec #(.DEC_TNEW(1'b1)) u_rec_m (
    .clk      (clk),
    .reset    (reset),
    .rec_i    (e_rec),
    .bubble_i (1'b0),
    .rec_o    (m_rec)
  );

  // W results are always available, so its tnew is never consulted
  hazard_stage_rec #(.DEC_TNEW(1'b0)) u_rec_w (
    .clk      (clk),
    .reset    (reset),
    .rec_i    (m_rec),
    .bubble_i (1'b0),
    .rec_o    (w_rec)
  );

  // RAW stall: a producer in E or M cannot deliver before the D operand is used
  assign raw_stall_c = raw_stall(hif.rs_D, hif.tuse_rs_D, e_rec) |
                       raw_stall(hif.rt_D, hif.tuse_rt_D, e_rec) |
                       raw_stall(hif.rs_D, hif.tuse_rs_D, m_rec) |
                       raw_stall(hif.rt_D, hif.tuse_rt_D, m_rec);

`ifdef HAZ_MD_STALL_EN
  localparam int unsigned MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int          CNT_W  = (MD_MAX > 1) ? $clog2(MD_MAX + 1) : 1;

  logic [CNT_W-1:0] md_cnt_d;
  logic [CNT_W-1:0] md_cnt_q;

  // Busy counter: reload when a mult/div actually enters E, else drain to 0
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (!stall_c && (hif.md_op_D == MDOP_MULT)) begin
      md_cnt_d = CNT_W'(MULT_CYC);
    end else if (!stall_c && (hif.md_op_D == MDOP_DIV)) begin
      md_cnt_d = CNT_W'(DIV_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  // Any HI/LO user, including a new mult/div, waits out the busy unit
  assign md_stall_c = hif.md_use_D & (md_cnt_q != '0);

  logic unused_rec;
  assign unused_rec = ^{w_rec.rs, w_rec.rt, w_rec.tnew, m_rec.rs};
`else
  assign md_stall_c = 1'b0;

  logic unused_rec;
  assign unused_rec = ^{w_rec.rs, w_rec.rt, w_rec.tnew, m_rec.rs,
                        hif.md_op_D, hif.md_use_D,
                        32'(MULT_CYC), 32'(DIV_CYC)};
`endif

  assign stall_c   = raw_stall_c | md_stall_c;
  assign hif.stall = stall_c;

  // Forwarding selects; D consumers look at M/W, E consumers at M/W,
  // and the M store data can only be fed from W
  assign hif.MCMP1D = fwd_sel(hif.rs_D, m_rec, w_rec);
  assign hif.MCMP2D = fwd_sel(hif.rt_D, m_rec, w_rec);
  assign hif.MALUAE = fwd_sel(e_rec.rs, m_rec, w_rec);
  assign hif.MALUBE = fwd_sel(e_rec.rt, m_rec, w_rec);
  assign hif.MWDM   = reg_match(m_rec.rt, w_rec.dst) ? w_sel(w_rec.kind) : SEL_NONE;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl
//   Self-checking bench for hazard_fwd_ctrl: directed instruction-sequence
//   table, hand-written mult/div busy sequences, then random instruction
//   streams checked against an in-order pipeline model that ages each
//   in-flight instruction by stage position. Honours HAZ_MD_STALL_EN.
module tb_hazard_fwd_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
`ifdef HAZ_MD_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  hazard_fwd_ctrl_if hif();

  hazard_fwd_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decoded D-stage instruction
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuseRs;
    logic [1:0] tuseRt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [2:0] kind;
    logic [1:0] mdOp;
    logic       mdUse;
  } dIn_t;

  // Directed vector: reset level, D instruction, expected {stall, 5 selects}
  typedef struct {
    string       name;
    bit          rstn;
    dIn_t        d;
    logic [20:0] exp;
  } vec_t;

  // Model of one in-flight instruction; tnew is kept as issued
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    int         tnew;
    int         kind;
  } slot_t;

  vec_t        tbl[$];
  slot_t       pipe[3];
  int          mdLeft;
  int          vecCount;
  int          missCount;
  logic [20:0] curExp;
  bit          curRstn;
  dIn_t        curD;
  int          mCode[5] = '{1, 0, 2, 3, 4};

  // Instruction builders
  function automatic dIn_t nop();
    dIn_t d;
    d.rs = 0; d.rt = 0; d.tuseRs = 3; d.tuseRt = 3; d.dst = 0;
    d.tnew = 0; d.kind = 0; d.mdOp = 0; d.mdUse = 0;
    return d;
  endfunction

  function automatic dIn_t alu(input int dst, input int rs, input int rt);
    dIn_t d = nop();
    d.rs = 5'(rs); d.rt = 5'(rt); d.tuseRs = 1; d.tuseRt = 1;
    d.dst = 5'(dst); d.tnew = 1; d.kind = 0;
    return d;
  endfunction

  function automatic dIn_t ld(input int dst, input int base);
    dIn_t d = nop();
    d.rs = 5'(base); d.tuseRs = 1; d.dst = 5'(dst); d.tnew = 2; d.kind = 1;
    return d;
  endfunction

  function automatic dIn_t st(input int src, input int base);
    dIn_t d = nop();
    d.rs = 5'(base); d.tuseRs = 1; d.rt = 5'(src); d.tuseRt = 2;
    return d;
  endfunction

  function automatic dIn_t br(input int rs, input int rt);
    dIn_t d = nop();
    d.rs = 5'(rs); d.rt = 5'(rt); d.tuseRs = 0; d.tuseRt = 0;
    return d;
  endfunction

  function automatic dIn_t jal();
    dIn_t d = nop();
    d.dst = 5'd31; d.tnew = 0; d.kind = 2;
    return d;
  endfunction

  function automatic dIn_t jr(input int rs);
    dIn_t d = nop();
    d.rs = 5'(rs); d.tuseRs = 0;
    return d;
  endfunction

  function automatic dIn_t mfhl(input int dst, input bit lo);
    dIn_t d = nop();
    d.dst = 5'(dst); d.tnew = 1; d.kind = lo ? 3'd4 : 3'd3; d.mdUse = 1;
    return d;
  endfunction

  function automatic dIn_t mdiv(input int rs, input int rt, input int op);
    dIn_t d = nop();
    d.rs = 5'(rs); d.rt = 5'(rt); d.tuseRs = 1; d.tuseRt = 1;
    d.mdOp = 2'(op); d.mdUse = 1;
    return d;
  endfunction

  function automatic logic [20:0] outs(input bit s, input int c1, input int c2,
                                       input int a, input int b, input int w);
    return {s, 4'(c1), 4'(c2), 4'(a), 4'(b), 4'(w)};
  endfunction

  function automatic vec_t mkv(input string name, input bit rstn, input dIn_t d,
                               input logic [20:0] exp);
    vec_t v;
    v.name = name; v.rstn = rstn; v.d = d; v.exp = exp;
    return v;
  endfunction

  // Reference model: remaining latency follows from how far the slot has
  // travelled past E; anything in W is complete
  function automatic int remain(input int s);
    int r;
    if (s >= 2) return 0;
    r = pipe[s].tnew - s;
    return (r > 0) ? r : 0;
  endfunction

  function automatic bit hits(input logic [4:0] r, input int s);
    return (r != 0) && (r == pipe[s].dst);
  endfunction

  function automatic int wCode(input int s);
    return (pipe[s].kind <= 4) ? 5 + pipe[s].kind : 0;
  endfunction

  function automatic int selFor(input logic [4:0] r);
    if (hits(r, 1) && remain(1) == 0) return (pipe[1].kind <= 4) ? mCode[pipe[1].kind] : 0;
    if (hits(r, 2)) return wCode(2);
    return 0;
  endfunction

  function automatic logic [20:0] modelExpect(input dIn_t d);
    bit s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (hits(d.rs, k) && remain(k) > int'(d.tuseRs)) s = 1'b1;
      if (hits(d.rt, k) && remain(k) > int'(d.tuseRt)) s = 1'b1;
    end
    if (MD_EN && d.mdUse && mdLeft > 0) s = 1'b1;
    return outs(s, selFor(d.rs), selFor(d.rt), selFor(pipe[0].rs), selFor(pipe[0].rt),
                hits(pipe[1].rt, 2) ? wCode(2) : 0);
  endfunction

  function automatic void modelAdvance(input bit rstn, input dIn_t d, input bit s);
    if (!rstn) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      mdLeft = 0;
      return;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (s) pipe[0] = '{default: 0};
    else   pipe[0] = '{d.rs, d.rt, d.dst, int'(d.tnew), int'(d.kind)};
    if (!s && d.mdOp == 2'd1)      mdLeft = MULT_CYC;
    else if (!s && d.mdOp == 2'd2) mdLeft = DIV_CYC;
    else if (mdLeft > 0)           mdLeft = mdLeft - 1;
  endfunction

  // Drive D inputs away from the rising edge and compute the model's view
  task automatic applyStimulus(input bit rstn, input dIn_t d);
    @(negedge clk);
    reset         = rstn;
    hif.rs_D      = d.rs;
    hif.rt_D      = d.rt;
    hif.tuse_rs_D = d.tuseRs;
    hif.tuse_rt_D = d.tuseRt;
    hif.dst_D     = d.dst;
    hif.tnew_D    = d.tnew;
    hif.kind_D    = d.kind;
    hif.md_op_D   = d.mdOp;
    hif.md_use_D  = d.mdUse;
    curRstn = rstn;
    curD    = d;
    #1;
    curExp = modelExpect(d);
  endtask

  task automatic checkOutput(input string name, input logic [20:0] exp);
    logic [20:0] got;
    got = {hif.stall, hif.MCMP1D, hif.MCMP2D, hif.MALUAE, hif.MALUBE, hif.MWDM};
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got stall=%0d cmp1=%0d cmp2=%0d aluA=%0d aluB=%0d wdm=%0d, expected stall=%0d cmp1=%0d cmp2=%0d aluA=%0d aluB=%0d wdm=%0d",
               name, got[20], got[19:16], got[15:12], got[11:8], got[7:4], got[3:0],
               exp[20], exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic endCycle();
    @(posedge clk);
    modelAdvance(curRstn, curD, curExp[20]);
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 7) ? 5'd31 : 5'($urandom_range(0, 5));
  endfunction

  function automatic dIn_t randInstr();
    case ($urandom_range(0, 11))
      0, 1:    return alu(rreg(), rreg(), rreg());
      2, 3:    return ld(rreg(), rreg());
      4:       return st(rreg(), rreg());
      5, 6:    return br(rreg(), rreg());
      7:       return jal();
      8:       return jr(rreg());
      9:       return mfhl(rreg(), $urandom_range(0, 1) == 1);
      10:      return mdiv(rreg(), rreg(), $urandom_range(1, 2));
      default: return nop();
    endcase
  endfunction

  task automatic addFlush();
    for (int k = 0; k < 3; k++) tbl.push_back(mkv("flush", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
  endtask

  task automatic buildTable();
    tbl.push_back(mkv("reset_state", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
    // ALU result feeding a branch compare
    tbl.push_back(mkv("addu1", 1, alu(1, 2, 3), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("beq_stall", 1, br(1, 2), outs(1, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("beq_M_ALU", 1, br(1, 2), outs(0, 1, 0, 0, 0, 0)));
    tbl.push_back(mkv("beqE_W_ALU", 1, nop(), outs(0, 0, 0, 5, 0, 0)));
    addFlush();
    // Load-use
    tbl.push_back(mkv("lw3", 1, ld(3, 6), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("addu_stall", 1, alu(4, 3, 0), outs(1, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("addu_go", 1, alu(4, 3, 0), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("adduE_W_DM", 1, nop(), outs(0, 0, 0, 6, 0, 0)));
    addFlush();
    // jal -> jr through M
    tbl.push_back(mkv("jal_a", 1, jal(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("gap_a", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("jr_M_PC", 1, jr(31), outs(0, 2, 0, 0, 0, 0)));
    tbl.push_back(mkv("jrE_W_PC", 1, nop(), outs(0, 0, 0, 7, 0, 0)));
    addFlush();
    // jal -> jr through W
    tbl.push_back(mkv("jal_b", 1, jal(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("gap_b1", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("gap_b2", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("jr_W_PC", 1, jr(31), outs(0, 7, 0, 0, 0, 0)));
    addFlush();
    // Load then store of the loaded value
    tbl.push_back(mkv("lw5", 1, ld(5, 6), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("sw5_nostall", 1, st(5, 7), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("swE", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("swM_W_DM", 1, nop(), outs(0, 0, 0, 0, 0, 6)));
    addFlush();
    // Register 0 never matches
    tbl.push_back(mkv("addu0", 1, alu(0, 2, 3), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("beq0", 1, br(0, 0), outs(0, 0, 0, 0, 0, 0)));
    addFlush();
    // Stall together with a W forward on the other operand
    tbl.push_back(mkv("alu2", 1, alu(2, 0, 0), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("gap_c", 1, nop(), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("lw3b", 1, ld(3, 0), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("br_stall_W", 1, br(3, 2), outs(1, 0, 5, 0, 0, 0)));
    tbl.push_back(mkv("br_stall_M", 1, br(3, 2), outs(1, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("br_W_DM", 1, br(3, 2), outs(0, 6, 0, 0, 0, 0)));
    addFlush();
    // Reset asserted while stalling
    tbl.push_back(mkv("addu1r", 1, alu(1, 2, 3), outs(0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("rst_midstall", 0, br(1, 2), outs(1, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv("after_reset", 1, br(1, 2), outs(0, 0, 0, 0, 0, 0)));
    addFlush();
  endtask

  // Main sequence
  initial begin
    vec_t v;
    bit   r;
    dIn_t d;
    vecCount  = 0;
    missCount = 0;
    mdLeft    = 0;
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    curRstn = 1'b0;
    curD    = nop();
    curExp  = '0;
    reset   = 1'b0;
    d       = nop();
    hif.rs_D = d.rs; hif.rt_D = d.rt; hif.tuse_rs_D = d.tuseRs; hif.tuse_rt_D = d.tuseRt;
    hif.dst_D = d.dst; hif.tnew_D = d.tnew; hif.kind_D = d.kind;
    hif.md_op_D = d.mdOp; hif.md_use_D = d.mdUse;
    repeat (2) @(posedge clk);

    buildTable();
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      applyStimulus(v.rstn, v.d);
      checkOutput($sformatf("%s#%0d", v.name, i), v.exp);
      endCycle();
    end

    // mult then mfhi: HI/LO user waits out the busy unit
    applyStimulus(1, mdiv(2, 3, 1));
    checkOutput("mult_issue", outs(0, 0, 0, 0, 0, 0));
    endCycle();
    for (int i = 0; i <= MULT_CYC; i++) begin
      applyStimulus(1, mfhl(8, 0));
      checkOutput($sformatf("mfhi_wait%0d", i), outs(MD_EN && (i < MULT_CYC), 0, 0, 0, 0, 0));
      endCycle();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, nop());
      checkOutput("md_flush", outs(0, 0, 0, 0, 0, 0));
      endCycle();
    end

    // div then mflo
    applyStimulus(1, mdiv(4, 5, 2));
    checkOutput("div_issue", outs(0, 0, 0, 0, 0, 0));
    endCycle();
    for (int i = 0; i <= DIV_CYC; i++) begin
      applyStimulus(1, mfhl(9, 1));
      checkOutput($sformatf("mflo_wait%0d", i), outs(MD_EN && (i < DIV_CYC), 0, 0, 0, 0, 0));
      endCycle();
    end

    // Random instruction stream against the model
    for (int n = 0; n < 800; n++) begin
      r = ($urandom_range(0, 60) != 0);
      d = randInstr();
      applyStimulus(r, d);
      checkOutput($sformatf("rand%0d", n), curExp);
      endCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
